// File: rtl/delay_sched_pkg.sv
// Shared constants and the sequencer state encoding for the delay fire scheduler.
// No logic of its own; imported by the scheduler top.
// A delay of all ones marks a channel as disabled.
package delay_sched_pkg;

  localparam int DEF_N_CH   = 4;
  localparam int DEF_ADDR_W = 11;
  localparam int DEF_DLY_W  = 24;

  localparam logic [23:0] DIS_CODE = 24'hFFFFFF;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WAIT = 3'd2,
    ST_RUN  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/delay_chan_timer.sv
// One channel countdown: loaded with a delay, pulses fire once when it expires.
// Latency: fire is registered; a zero delay fires the cycle after load.
// No backpressure: load/en/clr are plain controls from the scheduler FSM.
module delay_chan_timer #(
  parameter int              DLY_W   = 24,
  parameter logic [DLY_W-1:0] DIS_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic             clr,
  input  logic [DLY_W-1:0] load_dly,
  output logic             fire,
  output logic             done
);

  logic [DLY_W-1:0] cnt;
  logic             is_dis;
  logic             is_zero;

  assign is_dis  = (load_dly == DIS_VAL);
  assign is_zero = (load_dly == '0);

  // Countdown: done stays set after firing so the counter never wraps or refires.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt  <= '0;
      fire <= 1'b0;
      done <= 1'b0;
    end else begin
      fire <= 1'b0;
      if (load) begin
        cnt  <= is_dis ? '0 : load_dly;
        done <= is_dis || is_zero;
        fire <= is_zero;
      end else if (en && !done) begin
        cnt <= cnt - 1'b1;
        if (cnt == DLY_W'(1)) begin
          fire <= 1'b1;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/delay_fire_scheduler.sv
// Trigger-driven playback: reads four delay RAMs at one wave ID and fires each channel at its delay.
// Latency: fire on channel k at T+2+RAM_RD_LAT+D_k after trigger cycle T; all outputs registered.
// No backpressure: triggers arriving while busy are dropped and flagged on O_trig_drop.
module delay_fire_scheduler
  import delay_sched_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DLY_W      = DEF_DLY_W,
  parameter int RAM_RD_LAT = 1
) (
  input  logic              I_clk_10M,
  input  logic              I_rst,
  input  logic              I_trig,
  input  logic [ADDR_W-1:0] I_wave_id,
  input  logic              I_abort,
  output logic              O_RD_EN,
  output logic [ADDR_W-1:0] O_RD_ADDR,
  input  logic [DLY_W-1:0]  I_RD_DELAY_RAM1,
  input  logic [DLY_W-1:0]  I_RD_DELAY_RAM2,
  input  logic [DLY_W-1:0]  I_RD_DELAY_RAM3,
  input  logic [DLY_W-1:0]  I_RD_DELAY_RAM4,
  output logic [3:0]        O_FIRE,
  output logic              O_busy,
  output logic              O_done,
  output logic              O_trig_drop
);

  localparam int               N_CH    = DEF_N_CH;
  localparam logic [DLY_W-1:0] DIS_VAL = DLY_W'(DIS_CODE);

  state_t           state;
  logic [1:0]       wait_cnt;
  logic [DLY_W-1:0] dly [N_CH];
  logic [N_CH-1:0]  chan_fire;
  logic [N_CH-1:0]  chan_done;
  logic             active;
  logic             abort_now;
  logic             accept;
  logic             wait_last;
  logic             load;
  logic             run_en;
  logic             clr;
  logic             all_done;

  assign dly[0] = I_RD_DELAY_RAM1;
  assign dly[1] = I_RD_DELAY_RAM2;
  assign dly[2] = I_RD_DELAY_RAM3;
  assign dly[3] = I_RD_DELAY_RAM4;

  // Abort only matters once a sequence is in flight; in IDLE it just vetoes a trigger.
  assign active    = (state != ST_IDLE);
  assign abort_now = I_abort && active;
  assign accept    = (state == ST_IDLE) && I_trig && !I_abort;
  assign wait_last = (wait_cnt == 2'(RAM_RD_LAT - 1));
  assign load      = (state == ST_WAIT) && wait_last && !I_abort;
  assign run_en    = (state == ST_RUN) && !I_abort;
  assign clr       = abort_now || (state == ST_DONE);
  assign all_done  = &chan_done;

  // Sequencer FSM plus the registered handshake outputs.
  always_ff @(posedge I_clk_10M) begin
    if (I_rst) begin
      state       <= ST_IDLE;
      wait_cnt    <= 2'd0;
      O_RD_EN     <= 1'b0;
      O_RD_ADDR   <= '0;
      O_busy      <= 1'b0;
      O_done      <= 1'b0;
      O_trig_drop <= 1'b0;
    end else begin
      O_RD_EN     <= 1'b0;
      O_done      <= 1'b0;
      O_trig_drop <= I_trig && (active || I_abort);
      if (abort_now) begin
        state  <= ST_IDLE;
        O_busy <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (accept) begin
              state     <= ST_RD;
              O_busy    <= 1'b1;
              O_RD_EN   <= 1'b1;
              O_RD_ADDR <= I_wave_id;
            end
          end
          ST_RD: begin
            state    <= ST_WAIT;
            wait_cnt <= 2'd0;
          end
          ST_WAIT: begin
            if (wait_last) begin
              state <= ST_RUN;
            end else begin
              wait_cnt <= wait_cnt + 2'd1;
            end
          end
          ST_RUN: begin
            if (all_done) begin
              state  <= ST_DONE;
              O_done <= 1'b1;
            end
          end
          ST_DONE: begin
            state  <= ST_IDLE;
            O_busy <= 1'b0;
          end
          default: begin
            state  <= ST_IDLE;
            O_busy <= 1'b0;
          end
        endcase
      end
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_chan
    delay_chan_timer #(
      .DLY_W   (DLY_W),
      .DIS_VAL (DIS_VAL)
    ) u_timer (
      .clk      (I_clk_10M),
      .rst      (I_rst),
      .load     (load),
      .en       (run_en),
      .clr      (clr),
      .load_dly (dly[k]),
      .fire     (chan_fire[k]),
      .done     (chan_done[k])
    );
  end

  assign O_FIRE = chan_fire;

endmodule

// File: tb/tb_delay_fire_scheduler.sv
// Bench for delay_fire_scheduler: three instances at read latency 1, 2 and 3 share one stimulus.
// Each lane has its own RAM pipeline and an event-time model checked every cycle.
// Directed literal checks on the latency-1 lane pin the model to hand-computed cycles.
module tb_delay_fire_scheduler;

  localparam logic [23:0] DIS = 24'hFFFFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        trig;
  logic        abort;
  logic [10:0] wave_id;

  logic [23:0] mem [4][2048];

  logic [2:0]  rd_en_o;
  logic [10:0] addr_o [3];
  logic [3:0]  fire_o [3];
  logic [2:0]  busy_o;
  logic [2:0]  done_o;
  logic [2:0]  drop_o;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  always #50 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int lane, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s lane%0d cyc=%0d got=%0h want=%0h", nm, lane, cyc, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int LAT = g + 1;

    logic [23:0] p0 [4];
    logic [23:0] p1 [4];
    logic [23:0] p2 [4];
    logic [23:0] rdat [4];

    bit          started = 1'b0;
    bit          m_act   = 1'b0;
    int          t_acc   = 0;
    int          done_t  = 0;
    int          fire_t [4];
    bit          en_k [4];
    logic [10:0] e_addr  = '0;
    logic        e_busy  = 1'b0;
    logic        e_rden  = 1'b0;
    logic        e_done  = 1'b0;
    logic        e_drop  = 1'b0;
    logic [3:0]  e_fire  = '0;

    delay_fire_scheduler #(.RAM_RD_LAT(LAT)) dut (
      .I_clk_10M       (clk),
      .I_rst           (rst),
      .I_trig          (trig),
      .I_wave_id       (wave_id),
      .I_abort         (abort),
      .O_RD_EN         (rd_en_o[g]),
      .O_RD_ADDR       (addr_o[g]),
      .I_RD_DELAY_RAM1 (rdat[0]),
      .I_RD_DELAY_RAM2 (rdat[1]),
      .I_RD_DELAY_RAM3 (rdat[2]),
      .I_RD_DELAY_RAM4 (rdat[3]),
      .O_FIRE          (fire_o[g]),
      .O_busy          (busy_o[g]),
      .O_done          (done_o[g]),
      .O_trig_drop     (drop_o[g])
    );

    // RAM model: read data appears LAT cycles after the address is presented.
    always @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
        p0[k] <= mem[k][addr_o[g]];
        p1[k] <= p0[k];
        p2[k] <= p1[k];
      end
    end

    always_comb begin
      for (int k = 0; k < 4; k++) begin
        rdat[k] = (LAT == 1) ? p0[k] : (LAT == 2) ? p1[k] : p2[k];
      end
    end

    // Model: on accept, compute absolute cycles of every event; outputs follow from those times.
    initial begin : model
      int  c;
      int  n;
      int  mx;
      bit  nonidle;
      forever begin
        @(posedge clk);
        c = cyc;
        if (rst) begin
          m_act   = 1'b0;
          e_addr  = '0;
          e_drop  = 1'b0;
          started = 1'b1;
        end else begin
          nonidle = m_act && (c <= done_t);
          e_drop  = trig && (nonidle || abort);
          if (nonidle && abort) begin
            m_act = 1'b0;
          end else if (!nonidle && trig && !abort) begin
            m_act  = 1'b1;
            t_acc  = c;
            e_addr = wave_id;
            mx     = c + 2 + LAT;
            for (int k = 0; k < 4; k++) begin
              en_k[k]   = (mem[k][wave_id] != DIS);
              fire_t[k] = c + 2 + LAT + int'(mem[k][wave_id]);
              if (en_k[k] && fire_t[k] > mx) mx = fire_t[k];
            end
            done_t = mx + 1;
          end
        end
        n      = c + 1;
        e_busy = m_act && (n > t_acc) && (n <= done_t);
        e_rden = m_act && (n == t_acc + 1);
        e_done = m_act && (n == done_t);
        for (int k = 0; k < 4; k++) begin
          e_fire[k] = m_act && en_k[k] && (n == fire_t[k]);
        end
      end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin : compare
      forever begin
        @(negedge clk);
        if (started) begin
          chk("fire",    g, 32'(fire_o[g]), 32'(e_fire));
          chk("busy",    g, 32'(busy_o[g]), 32'(e_busy));
          chk("done",    g, 32'(done_o[g]), 32'(e_done));
          chk("drop",    g, 32'(drop_o[g]), 32'(e_drop));
          chk("rd_en",   g, 32'(rd_en_o[g]), 32'(e_rden));
          chk("rd_addr", g, 32'(addr_o[g]), 32'(e_addr));
        end
      end
    end
  end

  initial begin : stim
    logic [3:0] seen;
    rst     = 1'b1;
    trig    = 1'b0;
    abort   = 1'b0;
    wave_id = '0;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 2048; i++) mem[k][i] = DIS;
    end
    mem[0][5] = 24'd3;   mem[1][5] = 24'd0;   mem[2][5] = 24'd10;  mem[3][5] = DIS;
    for (int k = 0; k < 4; k++) begin
      mem[k][1] = 24'd0;
      mem[k][2] = 24'd100;
      mem[k][3] = 24'd50;
      mem[k][4] = 24'd20;
    end
    mem[0][9] = 24'd5;   mem[1][9] = 24'd6;   mem[2][9] = 24'd7;   mem[3][9] = 24'd8;

    // Reset state.
    step(3);
    chk("rst_fire", 0, 32'(fire_o[0]), 32'd0);
    chk("rst_busy", 0, 32'(busy_o[0]), 32'd0);
    chk("rst_addr", 0, 32'(addr_o[0]), 32'd0);
    rst = 1'b0;
    step(2);

    // Mixed delays {3,0,10,DIS}, then trigger in DONE (dropped) and the cycle after (accepted).
    trig = 1'b1; wave_id = 11'd5;
    step(1); trig = 1'b0;                                   // T+1
    chk("t1_busy", 0, 32'(busy_o[0]), 32'd1);
    chk("t1_rden", 0, 32'(rd_en_o[0]), 32'd1);
    chk("t1_addr", 0, 32'(addr_o[0]), 32'd5);
    step(2);                                                // T+3
    chk("t1_fire1", 0, 32'(fire_o[0]), 32'b0010);
    step(3);                                                // T+6
    chk("t1_fire0", 0, 32'(fire_o[0]), 32'b0001);
    step(7);                                                // T+13
    chk("t1_fire2", 0, 32'(fire_o[0]), 32'b0100);
    step(1);                                                // T+14
    chk("t1_done", 0, 32'(done_o[0]), 32'd1);
    trig = 1'b1; wave_id = 11'd7;
    step(1);                                                // T+15
    chk("t1_drop_in_done", 0, 32'(drop_o[0]), 32'd1);
    chk("t1_busy_low", 0, 32'(busy_o[0]), 32'd0);
    step(1); trig = 1'b0;                                   // T+16
    chk("t2_accept", 0, 32'(busy_o[0]), 32'd1);
    chk("t2_addr", 0, 32'(addr_o[0]), 32'd7);
    step(3);                                                // T+19 = T'+4
    chk("t2_alldis_done", 0, 32'(done_o[0]), 32'd1);
    chk("t2_alldis_fire", 0, 32'(fire_o[0]), 32'd0);
    step(10);

    // Latency sweep: zero delays fire all four channels at T+2+LAT.
    trig = 1'b1; wave_id = 11'd1;
    step(1); trig = 1'b0;                                   // T+1
    for (int j = 2; j <= 5; j++) begin
      step(1);                                              // T+j
      for (int g = 0; g < 3; g++) begin
        chk("sweep_fire", g, 32'(fire_o[g]), (j == g + 3) ? 32'hF : 32'h0);
      end
    end
    step(10);

    // Trigger while busy: dropped, first sequence timing unchanged.
    trig = 1'b1; wave_id = 11'd2;
    step(1); trig = 1'b0;                                   // T+1
    step(19);                                               // T+20
    trig = 1'b1; wave_id = 11'd5;
    step(1); trig = 1'b0;                                   // T+21
    chk("busy_drop", 0, 32'(drop_o[0]), 32'd1);
    chk("busy_still", 0, 32'(busy_o[0]), 32'd1);
    step(82);                                               // T+103
    chk("busy_fire", 0, 32'(fire_o[0]), 32'hF);
    step(1);                                                // T+104
    chk("busy_done", 0, 32'(done_o[0]), 32'd1);
    step(15);

    // Abort mid-sequence: busy drops next cycle, nothing fires afterwards.
    trig = 1'b1; wave_id = 11'd3;
    step(1); trig = 1'b0;                                   // T+1
    step(9); abort = 1'b1;                                  // T+10
    step(1); abort = 1'b0;                                  // T+11
    for (int g = 0; g < 3; g++) chk("abort_busy", g, 32'(busy_o[g]), 32'd0);
    seen = '0;
    for (int i = 0; i < 200; i++) begin
      seen = seen | fire_o[0] | fire_o[1] | fire_o[2] | {1'b0, done_o};
      step(1);
    end
    chk("abort_quiet", 0, 32'(seen), 32'd0);

    // Abort together with trigger in IDLE: abort wins, trigger flagged as dropped.
    trig = 1'b1; abort = 1'b1; wave_id = 11'd5;
    step(1); trig = 1'b0; abort = 1'b0;
    chk("abort_trig_drop", 0, 32'(drop_o[0]), 32'd1);
    chk("abort_trig_busy", 0, 32'(busy_o[0]), 32'd0);
    step(3);

    // Reset mid-RUN clears everything; a fresh trigger then runs normally.
    trig = 1'b1; wave_id = 11'd4;
    step(1); trig = 1'b0;                                   // T+1
    step(4); rst = 1'b1;                                    // T+5
    step(1); rst = 1'b0;                                    // T+6
    chk("mrst_busy", 0, 32'(busy_o[0]), 32'd0);
    chk("mrst_addr", 0, 32'(addr_o[0]), 32'd0);
    step(4);                                                // T+10
    trig = 1'b1; wave_id = 11'd4;
    step(1); trig = 1'b0;                                   // T+11
    step(21);                                               // T+32
    chk("mrst_early", 0, 32'(fire_o[0]), 32'h0);
    step(1);                                                // T+33
    chk("mrst_fire", 0, 32'(fire_o[0]), 32'hF);
    step(10);

    // RAM rewritten while running: loaded timers keep their values.
    trig = 1'b1; wave_id = 11'd9;
    step(1); trig = 1'b0;                                   // T+1
    step(5);                                                // T+6
    for (int k = 0; k < 4; k++) mem[k][9] = 24'd1;
    step(5);                                                // T+11
    chk("ramchg_fire3", 0, 32'(fire_o[0]), 32'b1000);
    step(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
